// File: rtl/cache_pkg.sv
// Shared definitions for the cache/memory arbiter: default widths and the
// arbiter state and owner encodings.
package cache_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY_D  = 2'b01,
        ST_BUSY_I  = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_e;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_e;

endpackage : cache_pkg

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, and on a tie the
// requester that did not own the memory last time wins.
module rr_pick2
    import cache_pkg::*;
(
    input  logic   d_req,
    input  logic   i_req,
    input  owner_e last,
    output logic   grant_valid,
    output owner_e grant
);

    // Select the winner among the active requesters
    always_comb begin
        grant_valid = d_req | i_req;
        grant       = OWN_D;
        if (d_req && i_req) begin
            grant = (last == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req) begin
            grant = OWN_I;
        end else begin
            grant = OWN_D;
        end
    end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// Shares the block memory port between the icache (read-only) and the
// dcache (read/write), holding each grant until memory completes.
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              started_q, started_d;
    logic [DATA_W-1:0] d_readdata_q, d_readdata_d;
    logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;

    logic   d_req_s;
    logic   i_req_s;
    logic   grant_valid_s;
    owner_e grant_s;
    logic   done_s;

    assign d_req_s = d_read | d_write;
    assign i_req_s = i_read;
    assign done_s  = started_q & ~mem_busywait;

    rr_pick2 u_pick (
        .d_req       (d_req_s),
        .i_req       (i_req_s),
        .last        (last_q),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Next-state, memory command and readdata capture
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        started_d       = started_q;
        d_readdata_d    = d_readdata_q;
        i_readdata_d    = i_readdata_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;

        case (state_q)
            ST_IDLE: begin
                started_d = 1'b0;
                if (grant_valid_s) begin
                    owner_d = grant_s;
                    // The command is captured at grant so memory keeps seeing
                    // it even if the requester lets go mid-transaction.
                    if (grant_s == OWN_D) begin
                        state_d         = ST_BUSY_D;
                        mem_read_d      = d_read & ~d_write;
                        mem_write_d     = d_write;
                        mem_address_d   = d_address;
                        mem_writedata_d = d_writedata;
                    end else begin
                        state_d         = ST_BUSY_I;
                        mem_read_d      = 1'b1;
                        mem_write_d     = 1'b0;
                        mem_address_d   = i_address;
                        mem_writedata_d = {DATA_W{1'b0}};
                    end
                end else begin
                    mem_read_d      = 1'b0;
                    mem_write_d     = 1'b0;
                    mem_address_d   = {ADDR_W{1'b0}};
                    mem_writedata_d = {DATA_W{1'b0}};
                end
            end
            ST_BUSY_D, ST_BUSY_I: begin
                if (done_s) begin
                    state_d   = ST_RELEASE;
                    last_d    = owner_q;
                    started_d = 1'b0;
                    if (mem_read_q) begin
                        if (owner_q == OWN_D) begin
                            d_readdata_d = mem_readdata;
                        end else begin
                            i_readdata_d = mem_readdata;
                        end
                    end else begin
                        d_readdata_d = d_readdata_q;
                    end
                    mem_read_d      = 1'b0;
                    mem_write_d     = 1'b0;
                    mem_address_d   = {ADDR_W{1'b0}};
                    mem_writedata_d = {DATA_W{1'b0}};
                end else if (mem_busywait) begin
                    started_d = 1'b1;
                end else begin
                    started_d = started_q;
                end
            end
            ST_RELEASE: begin
                state_d         = ST_IDLE;
                mem_read_d      = 1'b0;
                mem_write_d     = 1'b0;
                mem_address_d   = {ADDR_W{1'b0}};
                mem_writedata_d = {DATA_W{1'b0}};
            end
            default: begin
                state_d         = ST_IDLE;
                started_d       = 1'b0;
                mem_read_d      = 1'b0;
                mem_write_d     = 1'b0;
                mem_address_d   = {ADDR_W{1'b0}};
                mem_writedata_d = {DATA_W{1'b0}};
            end
        endcase
    end

    // Control and memory command registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_D;
            last_q          <= OWN_I;
            started_q       <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= {ADDR_W{1'b0}};
            mem_writedata_q <= {DATA_W{1'b0}};
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_q          <= last_d;
            started_q       <= started_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    // Readdata registers: a reset edge that aborts a transaction leaves them
    // alone; a reset seen while idle (any reset held two cycles) clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state_q == ST_IDLE) begin
                d_readdata_q <= {DATA_W{1'b0}};
                i_readdata_q <= {DATA_W{1'b0}};
            end else begin
                d_readdata_q <= d_readdata_q;
                i_readdata_q <= i_readdata_q;
            end
        end else begin
            d_readdata_q <= d_readdata_d;
            i_readdata_q <= i_readdata_d;
        end
    end

    assign d_busywait    = d_req_s & ~((state_q == ST_RELEASE) && (owner_q == OWN_D));
    assign i_busywait    = i_req_s & ~((state_q == ST_RELEASE) && (owner_q == OWN_I));
    assign d_readdata    = d_readdata_q;
    assign i_readdata    = i_readdata_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a task-driven memory responder.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        d_read, d_write;
    logic [5:0]  d_address;
    logic [31:0] d_writedata, d_readdata;
    logic        d_busywait;
    logic        i_read;
    logic [5:0]  i_address;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a memory strobe; caller is left at that negedge.
    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (mem_read || mem_write) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("strobe_timeout", 32'd0, 32'd1);
    endtask

    // Memory responder: busy for n cycles, then returns data.
    task automatic serve(input int n, input logic [31:0] data, input bit drop,
                         output logic [5:0] addr, output logic rd, output logic wr,
                         output logic [31:0] wdata, output logic db, output logic ib);
        bit ok;
        wait_strobe(ok);
        addr  = mem_address;
        rd    = mem_read;
        wr    = mem_write;
        wdata = mem_writedata;
        db    = d_busywait;
        ib    = i_busywait;
        mem_busywait = 1'b1;
        if (drop) begin
            d_read = 1'b0;
            i_read = 1'b0;
        end
        repeat (n) @(negedge clock);
        mem_busywait = 1'b0;
        mem_readdata = data;
    endtask

    logic [5:0]  a;
    logic        rd, wr, db, ib;
    logic [31:0] wd;
    bit          ok;

    initial begin
        reset = 1'b1;
        d_read = 1'b0; d_write = 1'b0; d_address = 6'h00; d_writedata = 32'h0;
        i_read = 1'b0; i_address = 6'h00;
        mem_readdata = 32'h0; mem_busywait = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_d_readdata", d_readdata, 32'h0);
        chk("rst_i_readdata", i_readdata, 32'h0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_address", {26'd0, mem_address}, 32'd0);
        chk("rst_busywaits", {30'd0, d_busywait, i_busywait}, 32'd0);
        reset = 1'b0;

        // dcache read alone
        d_read = 1'b1; d_address = 6'h05;
        serve(5, 32'hDEADBEEF, 1'b0, a, rd, wr, wd, db, ib);
        chk("t1_mem_read", {31'd0, rd}, 32'd1);
        chk("t1_mem_write", {31'd0, wr}, 32'd0);
        chk("t1_mem_address", {26'd0, a}, 32'h05);
        chk("t1_d_busywait_busy", {31'd0, db}, 32'd1);
        @(negedge clock);
        chk("t1_d_readdata", d_readdata, 32'hDEADBEEF);
        chk("t1_d_busywait_rel", {31'd0, d_busywait}, 32'd0);
        chk("t1_rel_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        d_read = 1'b0;
        @(negedge clock);
        chk("t1_idle_address", {26'd0, mem_address}, 32'h0);

        // Simultaneous requests after a one-cycle idle reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t2_reset_clears_d", d_readdata, 32'h0);
        d_read = 1'b1; d_address = 6'h01;
        i_read = 1'b1; i_address = 6'h02;
        serve(3, 32'hA1A1A1A1, 1'b0, a, rd, wr, wd, db, ib);
        chk("t2_first_grant", {26'd0, a}, 32'h01);
        chk("t2_i_wait_busy", {31'd0, ib}, 32'd1);
        @(negedge clock);
        chk("t2_d_readdata", d_readdata, 32'hA1A1A1A1);
        chk("t2_i_wait_rel", {31'd0, i_busywait}, 32'd1);
        d_read = 1'b0;
        serve(2, 32'hB2B2B2B2, 1'b0, a, rd, wr, wd, db, ib);
        chk("t2_second_grant", {26'd0, a}, 32'h02);
        @(negedge clock);
        chk("t2_i_readdata", i_readdata, 32'hB2B2B2B2);
        chk("t2_i_busywait_rel", {31'd0, i_busywait}, 32'd0);

        // Continuous contention: D, I, D, I (last is I here)
        d_read = 1'b1; d_address = 6'h10;
        i_read = 1'b1; i_address = 6'h20;
        for (int k = 0; k < 4; k++) begin
            serve(2, 32'hC0000000 + k, 1'b0, a, rd, wr, wd, db, ib);
            chk("t3_grant_order", {26'd0, a}, (k % 2 == 1) ? 32'h20 : 32'h10);
            @(negedge clock);
            chk("t3_rel_strobes", {30'd0, mem_read, mem_write}, 32'd0);
            if (k % 2 == 1) chk("t3_i_readdata", i_readdata, 32'hC0000000 + k);
            else            chk("t3_d_readdata", d_readdata, 32'hC0000000 + k);
        end
        d_read = 1'b0; i_read = 1'b0;
        @(negedge clock);

        // dcache write-back
        d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'h12345678;
        serve(3, 32'hFFFFFFFF, 1'b0, a, rd, wr, wd, db, ib);
        chk("t4_mem_write", {31'd0, wr}, 32'd1);
        chk("t4_mem_read", {31'd0, rd}, 32'd0);
        chk("t4_mem_address", {26'd0, a}, 32'h3F);
        chk("t4_mem_writedata", wd, 32'h12345678);
        @(negedge clock);
        chk("t4_d_readdata_kept", d_readdata, 32'hC0000002);
        chk("t4_d_busywait_rel", {31'd0, d_busywait}, 32'd0);
        d_write = 1'b0; d_writedata = 32'h0;

        // Reset two cycles into BUSY_I
        i_read = 1'b1; i_address = 6'h0A;
        wait_strobe(ok);
        chk("t5_mem_read", {31'd0, mem_read}, 32'd1);
        mem_busywait = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_reset_mem_read", {31'd0, mem_read}, 32'd0);
        chk("t5_i_readdata_kept", i_readdata, 32'hC0000003);
        chk("t5_i_busywait", {31'd0, i_busywait}, 32'd1);
        reset = 1'b0; mem_busywait = 1'b0;
        serve(2, 32'h5A5A5A5A, 1'b0, a, rd, wr, wd, db, ib);
        chk("t5_regrant_addr", {26'd0, a}, 32'h0A);
        @(negedge clock);
        chk("t5_i_readdata", i_readdata, 32'h5A5A5A5A);
        i_read = 1'b0;

        // icache drops its request mid-transaction
        @(negedge clock);
        i_read = 1'b1; i_address = 6'h07;
        serve(4, 32'h0F0F0F0F, 1'b1, a, rd, wr, wd, db, ib);
        chk("t6_addr", {26'd0, a}, 32'h07);
        chk("t6_mem_read_held", {31'd0, mem_read}, 32'd1);
        @(negedge clock);
        chk("t6_i_readdata", i_readdata, 32'h0F0F0F0F);
        chk("t6_i_busywait", {31'd0, i_busywait}, 32'd0);
        chk("t6_rel_strobe", {31'd0, mem_read}, 32'd0);
        repeat (2) @(negedge clock);
        chk("t6_no_regrant", {30'd0, mem_read, mem_write}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 32-bit-block data memory port between the instruction cache (read-only) and the data cache (read/write) of the 8-bit single-cycle processor. It grants one cache controller's block request at a time and forwards it unchanged to memory. It holds the grant until memory completes, then returns the fetched block to the owner. Ties are broken round-robin so neither cache can starve the other.

## Interface
- ADDR_W, 6, block address width (byte address [7:2])
- DATA_W, 32, block width
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- d_read  in  1  dcache block read request
- d_write  in  1  dcache block write-back request
- d_address  in  ADDR_W  dcache block address
- d_writedata  in  DATA_W  dcache write-back block
- d_readdata  out  DATA_W  block returned to dcache (registered)
- d_busywait  out  1  dcache stall
- i_read  in  1  icache block read request
- i_address  in  ADDR_W  icache block address
- i_readdata  out  DATA_W  block returned to icache (registered)
- i_busywait  out  1  icache stall
- mem_read, mem_write  out  1  memory strobes
- mem_address  out  ADDR_W  memory block address
- mem_writedata  out  DATA_W  memory write block
- mem_readdata  in  DATA_W  memory read block
- mem_busywait  in  1  memory busy

## Operation
- Request terms:
  - d_req = d_read|d_write.
  - i_req = i_read.
  - d_read&d_write together is treated as a write.
- States: IDLE, BUSY_D, BUSY_I, RELEASE. The owner register holds D or I. The last register holds the most recent owner.
- IDLE:
  - d_req only -> BUSY_D.
  - i_req only -> BUSY_I.
  - Both -> grant the one not equal to last.
  - Neither -> stay in IDLE.
- BUSY_x:
  - Forward the owner's strobes, address and writedata to memory. The icache never drives mem_write.
  - The started flag sets on the first edge that samples mem_busywait=1.
  - Completion is started && !mem_busywait, sampled at the edge. It transitions to RELEASE.
  - On a read completion, mem_readdata is latched into the owner's readdata register at that edge. last is updated to owner.
- RELEASE:
  - All mem_* strobes are 0.
  - The owner's busywait is 0 for exactly this cycle.
  - Next state is IDLE.
- Busywait outputs are combinational:
  - x_busywait = x_req && !(state==RELEASE && owner==x).
  - A requester with no request sees 0.
- Requester drops its request mid-BUSY: the transaction still runs to completion (memory cannot abort). The readdata is still latched.
- When idle, mem_address and mem_writedata are driven 0.

## Timing
- Reset values:
  - state=IDLE, owner=D, last=I (so the dcache wins the first tie), started=0.
  - d_readdata=0, i_readdata=0, all mem strobes 0.
- Reset mid-transaction: the next edge forces IDLE with strobes 0, readdata unchanged. The memory sees the strobe drop.
- Minimum latency from request to busywait low: 1 (IDLE->BUSY) + N (memory busy cycles) + 1 (completion edge) cycles.
- The readdata register is valid from the completion edge onward. It holds until the next completion for that port.
- Back-to-back: RELEASE always costs one cycle. A pending other requester is granted from the following IDLE.
- Fairness: under continuous contention, grants strictly alternate D, I, D, I.

## Structure
- Shared package cache_pkg holds:
  - ADDR_W and DATA_W defaults.
  - the arbiter state encoding (2 bits: IDLE=00, BUSY_D=01, BUSY_I=10, RELEASE=11).
  - the owner encoding (D=0, I=1).
- One natural sub-module: rr_pick2 (combinational two-way round-robin picker taking d_req, i_req, last). Everything else lives in mem_arbiter.

## Test plan
- dcache read alone, address 6'h05, memory busy 5 cycles, returns 32'hDEADBEEF:
  - mem_read=1, mem_address=05 during BUSY_D.
  - d_readdata=DEADBEEF.
  - d_busywait low one cycle after completion.
- Simultaneous d_read(6'h01) and i_read(6'h02) after reset:
  - dcache is granted first; i_busywait stays 1 throughout.
  - icache is granted after RELEASE+IDLE.
  - last=I afterwards.
- Continuous contention for 4 transactions: grant order D, I, D, I; no mem strobe active during any RELEASE cycle.
- dcache write-back to 6'h3F with data 32'h12345678: mem_write=1, mem_writedata=12345678; d_readdata unchanged.
- Reset asserted 2 cycles into BUSY_I:
  - Next edge gives state IDLE, mem_read=0.
  - i_readdata keeps its prior value.
  - A new i_read is re-granted cleanly.
- icache drops i_read mid-BUSY_I: memory completes, i_readdata is updated, the arbiter returns to IDLE, and i_busywait=0.
